// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The state encodings, the bus width and the NOP encoding live here.
package inst_fetch_resp_pkg;

  localparam int REG_BUS = 64;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFR_IDLE = 2'b00,
    IFR_BUSY = 2'b01,
    IFR_RESP = 2'b10
  } ifr_state_e;

  // Pick the 32-bit instruction out of a 64-bit RAM word using PC bit 2.
  function automatic logic [31:0] word_sel(input logic [63:0] data, input logic hi);
    if (hi) begin
      return data[63:32];
    end else begin
      return data[31:0];
    end
  endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: one outstanding PC fetch against a fixed-latency RAM.
// Optional statistics counters are enabled by defining INST_FETCH_RESP_STAT_EN.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [REG_BUS-1:0] req_pc,
  input  logic               flush,
  output logic               mem_en,
  output logic [63:0]        mem_addr,
  input  logic [63:0]        mem_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_inst,
  output logic [63:0]        resp_pc,
  output logic               resp_err
`ifdef INST_FETCH_RESP_STAT_EN
  ,
  output logic [63:0]        stat_fetch_cnt,
  output logic [63:0]        stat_stall_cnt
`endif
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  ifr_state_e   state;
  ifr_state_e   state_next;
  logic [2:0]   cnt;
  logic [63:0]  pc_q;
  logic [31:0]  resp_inst_q;
  logic [63:0]  resp_pc_q;
  logic         resp_err_q;
  logic         resp_valid_q;
  logic         accept;
  logic         aligned;

  assign accept  = req_valid && req_ready;
  assign aligned = (req_pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IFR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Flush outranks everything; a misaligned PC skips the RAM and responds directly.
  always_comb begin
    state_next = state;
    case (state)
      IFR_IDLE: begin
        if (accept) begin
          state_next = aligned ? IFR_BUSY : IFR_RESP;
        end else begin
          state_next = IFR_IDLE;
        end
      end
      IFR_BUSY: begin
        if (flush) begin
          state_next = IFR_IDLE;
        end else if (cnt == LAT) begin
          state_next = IFR_RESP;
        end else begin
          state_next = IFR_BUSY;
        end
      end
      IFR_RESP: begin
        if (flush) begin
          state_next = IFR_IDLE;
        end else if (resp_ready) begin
          if (accept) begin
            state_next = aligned ? IFR_BUSY : IFR_RESP;
          end else begin
            state_next = IFR_IDLE;
          end
        end else begin
          state_next = IFR_RESP;
        end
      end
      default: state_next = IFR_IDLE;
    endcase
  end

  always_comb begin
    req_ready = !flush && ((state == IFR_IDLE) || ((state == IFR_RESP) && resp_ready));
    mem_en    = req_valid && req_ready && aligned;
    mem_addr  = {req_pc[63:3], 3'b000};
  end

  // Counter starts at 1 in the first BUSY cycle so cnt==LAT lines up with valid RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 3'd0;
      pc_q         <= 64'd0;
      resp_inst_q  <= NOP_INST;
      resp_pc_q    <= 64'd0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= (state_next == IFR_RESP);
      if (accept) begin
        pc_q <= req_pc;
        cnt  <= 3'd1;
        if (!aligned) begin
          resp_inst_q <= NOP_INST;
          resp_pc_q   <= req_pc;
          resp_err_q  <= 1'b1;
        end
      end else if ((state == IFR_BUSY) && !flush) begin
        cnt <= cnt + 3'd1;
        if (cnt == LAT) begin
          resp_inst_q <= word_sel(mem_rdata, pc_q[2]);
          resp_pc_q   <= pc_q;
          resp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_pc    = resp_pc_q;
  assign resp_err   = resp_err_q;

`ifdef INST_FETCH_RESP_STAT_EN
  // Delivered responses and back-pressure cycles; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_cnt <= 64'd0;
      stat_stall_cnt <= 64'd0;
    end else begin
      if (resp_valid_q && resp_ready) begin
        stat_fetch_cnt <= stat_fetch_cnt + 64'd1;
      end
      if (resp_valid_q && !resp_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: four instances (MEM_LAT 1..4) share stimulus, one selected at a time.
// Expected responses go into a scoreboard queue and are checked by a monitor every valid cycle.
module tb_inst_fetch_resp;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        flush;
  logic        resp_ready;
  logic [63:0] req_pc;
  logic [1:0]  sel;
  int          cyc;
  int          tests;
  int          fails;

  logic        req_valid_a   [4];
  logic        req_ready_a   [4];
  logic        mem_en_a      [4];
  logic [63:0] mem_addr_a    [4];
  logic [63:0] mem_rdata_a   [4];
  logic        resp_valid_a  [4];
  logic [31:0] resp_inst_a   [4];
  logic [63:0] resp_pc_a     [4];
  logic        resp_err_a    [4];
`ifdef INST_FETCH_RESP_STAT_EN
  logic [63:0] stat_fetch_a  [4];
  logic [63:0] stat_stall_a  [4];
`endif

  logic        req_ready_s, mem_en_s, resp_valid_s, resp_err_s;
  logic [63:0] mem_addr_s, resp_pc_s;
  logic [31:0] resp_inst_s;

  logic        pv [4][4];
  logic [63:0] pa [4][4];

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
    int          due;
  } exp_t;
  exp_t sbq[$];
  bit   seen;

  typedef struct {
    int          k;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
    int          stalls;
  } vec_t;
  vec_t vecs[9];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    inst_fetch_resp #(.MEM_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_a[g]),
      .req_pc     (req_pc),
      .flush      (flush),
      .mem_en     (mem_en_a[g]),
      .mem_addr   (mem_addr_a[g]),
      .mem_rdata  (mem_rdata_a[g]),
      .resp_valid (resp_valid_a[g]),
      .resp_ready (resp_ready),
      .resp_inst  (resp_inst_a[g]),
      .resp_pc    (resp_pc_a[g]),
      .resp_err   (resp_err_a[g])
`ifdef INST_FETCH_RESP_STAT_EN
      ,
      .stat_fetch_cnt (stat_fetch_a[g]),
      .stat_stall_cnt (stat_stall_a[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00A0_0113_0050_0093;
    else if (a == 64'h0000_0000_8000_0008) return 64'h0020_8233_0020_81B3;
    else return {~a[31:0], a[31:0] + 32'h0000_0100};
  endfunction

  // RAM model: read data is only meaningful exactly MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pv[k][0] <= mem_en_a[k];
      pa[k][0] <= mem_addr_a[k];
      for (int s = 1; s < 4; s++) begin
        pv[k][s] <= pv[k][s-1];
        pa[k][s] <= pa[k][s-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_valid_a[k] = req_valid && (sel == 2'(k));
      mem_rdata_a[k] = pv[k][k] ? mem_word(pa[k][k]) : 64'hDEAD_BEEF_DEAD_BEEF;
    end
    req_ready_s  = req_ready_a[sel];
    mem_en_s     = mem_en_a[sel];
    mem_addr_s   = mem_addr_a[sel];
    resp_valid_s = resp_valid_a[sel];
    resp_inst_s  = resp_inst_a[sel];
    resp_pc_s    = resp_pc_a[sel];
    resp_err_s   = resp_err_a[sel];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic [63:0] pc, input logic err, input int due);
    exp_t e;
    e.inst = inst; e.pc = pc; e.err = err; e.due = due;
    sbq.push_back(e);
  endtask

  task automatic clear_sb();
    sbq.delete();
    seen = 1'b0;
  endtask

  // Monitor: first-valid latency, then contents (and hence stability) on every valid cycle.
  always @(negedge clk) begin
    if (!rst && resp_valid_s) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp_valid", 64'(resp_valid_s), 64'd0);
      end else begin
        if (!seen) begin
          check("resp_latency", 64'(cyc), 64'(sbq[0].due));
          seen = 1'b1;
        end
        check("resp_inst", 64'(resp_inst_s), 64'(sbq[0].inst));
        check("resp_pc", resp_pc_s, sbq[0].pc);
        check("resp_err", 64'(resp_err_s), 64'(sbq[0].err));
        if (resp_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic run_fetch(input int k, input logic [63:0] pc, input logic [31:0] inst,
                           input logic err, input int stalls);
    int stalled;
    int extra;
    bit done;
    sel = 2'(k); resp_ready = (stalls == 0); req_valid = 1'b1; req_pc = pc;
    @(negedge clk);
    check("req_ready_accept", 64'(req_ready_s), 64'd1);
    check("mem_en_accept", 64'(mem_en_s), 64'(!err));
    if (!err) check("mem_addr", mem_addr_s, {pc[63:3], 3'b000});
    push(inst, pc, err, cyc + (err ? 1 : k + 2));
    @(posedge clk); #1;
    req_valid = 1'b0;
    stalled = 0; extra = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_en_s) extra++;
      if (resp_valid_s) begin
        if (resp_ready) done = 1'b1;
        else stalled++;
      end
      @(posedge clk); #1;
      if (stalled >= stalls) resp_ready = 1'b1;
    end
    check("resp_handshake", 64'(done), 64'd1);
    check("mem_en_once", 64'(extra), 64'd0);
    if (!done) clear_sb();
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid_s) break;
      @(posedge clk); #1;
    end
    check("wait_valid", 64'(resp_valid_s), 64'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    clear_sb();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; seen = 1'b0;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1; req_pc = 64'd0; sel = 2'd0;
    for (int k = 0; k < 4; k++) for (int s = 0; s < 4; s++) begin
      pv[k][s] = 1'b0; pa[k][s] = 64'd0;
    end

    vecs[0] = '{0, 64'h0000_0000_8000_0000, 32'h0050_0093, 1'b0, 0};
    vecs[1] = '{2, 64'h0000_0000_8000_0004, 32'h00A0_0113, 1'b0, 0};
    vecs[2] = '{0, 64'h0000_0000_8000_0002, 32'h0000_0013, 1'b1, 0};
    vecs[3] = '{3, 64'h0000_0000_8000_000C, 32'h0020_8233, 1'b0, 2};
    vecs[4] = '{1, 64'h0000_0000_8000_0001, 32'h0000_0013, 1'b1, 1};
    vecs[5] = '{1, 64'h0000_0000_8000_0008, 32'h0020_81B3, 1'b0, 0};
    vecs[6] = '{3, 64'h0000_0000_8000_0003, 32'h0000_0013, 1'b1, 0};
    vecs[7] = '{2, 64'h0000_0000_0000_1000, 32'h0000_1100, 1'b0, 0};
    vecs[8] = '{0, 64'h0000_0000_0000_1004, 32'hFFFF_EFFF, 1'b0, 3};

    // Reset values on every instance
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_resp_valid", 64'(resp_valid_a[k]), 64'd0);
      check("rst_resp_inst", 64'(resp_inst_a[k]), 64'h13);
      check("rst_resp_pc", resp_pc_a[k], 64'd0);
      check("rst_resp_err", 64'(resp_err_a[k]), 64'd0);
      check("rst_mem_en", 64'(mem_en_a[k]), 64'd0);
      check("rst_req_ready", 64'(req_ready_a[k]), 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_fetch(vecs[i].k, vecs[i].pc, vecs[i].inst, vecs[i].err, vecs[i].stalls);
    end

    // Held response for 5 cycles, then back-to-back accept on the handshake
    sel = 2'd0; resp_ready = 1'b0; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0000;
    @(negedge clk);
    push(32'h0050_0093, req_pc, 1'b0, cyc + 2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid();
    check("stall_req_ready", 64'(req_ready_s), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready_s), 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0008;
    @(negedge clk);
    check("b2b_req_ready", 64'(req_ready_s), 64'd1);
    check("b2b_mem_en", 64'(mem_en_s), 64'd1);
    check("b2b_mem_addr", mem_addr_s, 64'h0000_0000_8000_0008);
    push(32'h0020_81B3, 64'h0000_0000_8000_0008, 1'b0, cyc + 2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();

    // Flush in IDLE blocks a request, then flush while BUSY (MEM_LAT=2)
    sel = 2'd1; flush = 1'b1; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0000;
    @(negedge clk);
    check("flush_idle_req_ready", 64'(req_ready_s), 64'd0);
    check("flush_idle_mem_en", 64'(mem_en_s), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_accept", 64'(mem_en_s), 64'd1);
    push(32'h0050_0093, req_pc, 1'b0, cyc + 3);
    @(posedge clk); #1;
    flush = 1'b1; req_pc = 64'h0000_0000_8000_0008;
    @(negedge clk);
    check("flush_busy_mem_en", 64'(mem_en_s), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    clear_sb();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_busy_no_valid", 64'(resp_valid_s), 64'd0);
      check("flush_busy_idle", 64'(req_ready_s), 64'd1);
      @(posedge clk); #1;
    end
    run_fetch(1, 64'h0000_0000_8000_0008, 32'h0020_81B3, 1'b0, 0);

    // Flush while a response is held
    sel = 2'd0; resp_ready = 1'b0; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0004;
    @(negedge clk);
    push(32'h00A0_0113, req_pc, 1'b0, cyc + 2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid();
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0008;
    @(negedge clk);
    check("flush_resp_req_ready", 64'(req_ready_s), 64'd0);
    check("flush_resp_mem_en", 64'(mem_en_s), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    clear_sb();
    @(negedge clk);
    check("flush_resp_dropped", 64'(resp_valid_s), 64'd0);
    check("flush_resp_idle", 64'(req_ready_s), 64'd1);
    @(posedge clk); #1;
    resp_ready = 1'b1;

    // Statistics window, then reset in the middle of a read
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_fetch(1, 64'h0000_0000_8000_0000, 32'h0050_0093, 1'b0, 1);
    run_fetch(1, 64'h0000_0000_8000_0004, 32'h00A0_0113, 1'b0, 0);
    run_fetch(1, 64'h0000_0000_8000_0008, 32'h0020_81B3, 1'b0, 3);
`ifdef INST_FETCH_RESP_STAT_EN
    @(negedge clk);
    check("stat_fetch_cnt", stat_fetch_a[1], 64'd3);
    check("stat_stall_cnt", stat_stall_a[1], 64'd4);
    @(posedge clk); #1;
`endif
    sel = 2'd1; req_valid = 1'b1; req_pc = 64'h0000_0000_8000_0000;
    @(negedge clk);
    check("pre_rst_accept", 64'(mem_en_s), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_busy_no_valid", 64'(resp_valid_s), 64'd0);
`ifdef INST_FETCH_RESP_STAT_EN
      check("rst_stat_fetch", stat_fetch_a[1], 64'd0);
      check("rst_stat_stall", stat_stall_a[1], 64'd0);
`endif
      @(posedge clk); #1;
    end
    run_fetch(1, 64'h0000_0000_8000_0004, 32'h00A0_0113, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
